// File: rtl/byte_register_pkg.sv
// rtl/byte_register_pkg.sv - shared constants for the byte-lane storage cells
package byte_register_pkg;

  localparam int                     BYTE_WIDTH          = 8;
  localparam logic [BYTE_WIDTH-1:0]  DEFAULT_RESET_VALUE = '0;

endpackage

// File: rtl/byte_register.sv
// rtl/byte_register.sv - byte-wide storage cell with synchronous load enable
// Output comes straight from the flops; read gating and tri-state belong to the parent.
module byte_register
  import byte_register_pkg::*;
#(
  parameter int               WIDTH       = BYTE_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  // Power-up value for simulation only; hardware relies on reset.
  logic [WIDTH-1:0] r_data = RESET_VALUE;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_data <= RESET_VALUE;
    end else if (write_enable) begin
      r_data <= data_in;
    end
  end

  assign data_out = r_data;

  // An unknown load enable would silently hold or load; make it visible.
  a_write_enable_known : assert property (@(posedge clock) !reset |-> !$isunknown(write_enable));

endmodule

// File: tb/tb_byte_register.sv
// tb/tb_byte_register.sv - directed scoreboard bench for byte_register
// Covers an 8-bit lane and a 16-bit instance with a non-zero reset value.
module tb_byte_register;

  logic        clk;
  logic        rst;
  logic        we8;
  logic [7:0]  din8;
  logic [7:0]  dout8;
  logic        we16;
  logic [15:0] din16;
  logic [15:0] dout16;

  int total;
  int bad;

  logic [7:0]  q8[$];
  logic [15:0] q16[$];

  byte_register u_dut8 (
    .clock        (clk),
    .reset        (rst),
    .write_enable (we8),
    .data_in      (din8),
    .data_out     (dout8)
  );

  byte_register #(
    .WIDTH       (16),
    .RESET_VALUE (16'hBEEF)
  ) u_dut16 (
    .clock        (clk),
    .reset        (rst),
    .write_enable (we16),
    .data_in      (din16),
    .data_out     (dout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of 8-bit stimulus, queue the expected post-edge value, then compare.
  task automatic step8(input string tag, input logic r, input logic w,
                       input logic [7:0] d, input logic [7:0] exp);
    logic [7:0] e;
    rst  = r;
    we8  = w;
    din8 = d;
    q8.push_back(exp);
    @(posedge clk);
    #1;
    e = q8.pop_front();
    chk8(tag, dout8, e);
  endtask

  task automatic step16(input string tag, input logic r, input logic w,
                        input logic [15:0] d, input logic [15:0] exp);
    logic [15:0] e;
    rst   = r;
    we16  = w;
    din16 = d;
    q16.push_back(exp);
    @(posedge clk);
    #1;
    e = q16.pop_front();
    chk16(tag, dout16, e);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    we8   = 1'b1;
    din8  = 8'hA5;
    we16  = 1'b0;
    din16 = 16'h0000;
    #1;

    // Reset priority over a concurrent write.
    step8("reset_edge1", 1'b1, 1'b1, 8'hA5, 8'h00);
    step8("reset_edge2", 1'b1, 1'b1, 8'hA5, 8'h00);

    // Single write: not visible before the edge, visible after.
    rst  = 1'b0;
    we8  = 1'b1;
    din8 = 8'h3C;
    #2;
    chk8("write_before_edge", dout8, 8'h00);
    step8("write_3c", 1'b0, 1'b1, 8'h3C, 8'h3C);

    // Hold with toggling data.
    for (int i = 0; i < 5; i++) begin
      step8("hold", 1'b0, 1'b0, (i % 2 == 0) ? 8'hFF : 8'h00, 8'h3C);
    end

    // Back-to-back writes.
    step8("b2b_01", 1'b0, 1'b1, 8'h01, 8'h01);
    step8("b2b_80", 1'b0, 1'b1, 8'h80, 8'h80);
    step8("b2b_ff", 1'b0, 1'b1, 8'hFF, 8'hFF);

    // Mid-operation reset discards the pending write; next write lands.
    step8("mid_reset", 1'b1, 1'b1, 8'h55, 8'h00);
    step8("post_reset_write", 1'b0, 1'b1, 8'h55, 8'h55);

    // Bit-independence patterns.
    step8("pattern_aa", 1'b0, 1'b1, 8'hAA, 8'hAA);
    step8("pattern_0f", 1'b0, 1'b1, 8'h0F, 8'h0F);
    step8("hold_0f", 1'b0, 1'b0, 8'hF0, 8'h0F);
    we8 = 1'b0;

    // Wide instance with a non-zero reset value.
    step16("w16_reset", 1'b1, 1'b1, 16'h1234, 16'hBEEF);
    step16("w16_reset_hold", 1'b0, 1'b0, 16'h1234, 16'hBEEF);
    step16("w16_write", 1'b0, 1'b1, 16'h1234, 16'h1234);
    step16("w16_hold", 1'b0, 1'b0, 16'hFFFF, 16'h1234);
    step16("w16_write_hi", 1'b0, 1'b1, 16'hA55A, 16'hA55A);
    chk8("lane_unaffected_by_w16", dout8, 8'h00);

    total++;
    assert (q8.size() == 0 && q16.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d expected=0", q8.size() + q16.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/byte_register.md
Name: byte_register

Overview:
- Generic byte-wide storage element with synchronous load enable; the basic storage cell of the register file.
- Pairs of instances form 16-bit registers: one per byte lane, each lane with its own write enable.
- The parent wraps the output with its own read-enable/tri-state logic. This block only stores data and always drives its output.

Parameters:
- WIDTH, 8, data width in bits; byte lanes use 8.
- RESET_VALUE, 0 (WIDTH bits), value loaded on reset.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- write_enable  input  1  load data_in on the next rising edge when high.
- data_in  input  WIDTH  data to store.
- data_out  output  WIDTH  stored value, driven directly from the flops.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. The ports are named clock and reset.
- Each rising edge of clock, in priority order:
  - reset=1: data_out <= RESET_VALUE. Reset wins over write_enable when both are high.
  - else write_enable=1: data_out <= data_in.
  - else: data_out holds its value.
- Write latency: data_out shows the new value one edge after write_enable is sampled high. No combinational path exists from data_in or write_enable to data_out.
- data_out is always driven (never Z or X after the first reset). Tri-state and read gating are the parent's job.
- Power-up: storage is initialised to RESET_VALUE for simulation. Real hardware relies on reset.
- Reset asserted mid-operation: the pending write is discarded and the register clears on that edge. The first write after reset deasserts takes effect normally.
- Back-to-back writes on consecutive cycles: each edge loads the current data_in. The last write wins.
- X on write_enable must not be masked silently. The simulation assertion flags it when reset is low.
- Bit-independence: every bit loads the same way. There is no masking, and no partial write inside the byte.

Decomposition:
- Shared package: constant BYTE_WIDTH=8 and the default reset-value constant, both reused by the 16-bit register wrapper and the register file.
- No sub-module needed. A single always block with a priority if/else is natural.
- The 16-bit wrapper that instantiates two of these lives elsewhere.

Test Plan:
- Reset: hold reset=1 for 2 edges with write_enable=1 and data_in=8'hA5 -> data_out=8'h00 (reset priority).
- Write: reset=0, write_enable=1, data_in=8'h3C for one edge -> data_out=8'h3C after that edge, not before.
- Hold: write_enable=0, data_in toggles 8'hFF/8'h00 for 5 edges -> data_out stays 8'h3C.
- Back-to-back: write 8'h01, 8'h80, 8'hFF on consecutive edges -> data_out follows 8'h01, 8'h80, 8'hFF edge by edge.
- Mid-operation reset: data_out=8'hFF, then reset=1 with write_enable=1 and data_in=8'h55 -> 8'h00. Next edge with reset=0 and write_enable=1 -> 8'h55.
- Parameter sweep: WIDTH=16, RESET_VALUE=16'hBEEF, reset -> 16'hBEEF. Write 16'h1234 -> 16'h1234.
